// File: rtl/twos_to_signmag_serial_pkg.sv
// Shared definitions for the serial two's-complement to sign-magnitude decoder.
// Holds the default word width and the FSM state encoding used by the top level.
package twos_to_signmag_serial_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/twos_to_signmag_serial_bit_cell.sv
// twos_neg_bit_cell: one step of the LSB-first negation rule.
// Positive words pass bits straight through. Negative words copy bits up to
// and including the first 1, then invert every later bit.
// Ports:
//   b             current input bit
//   sign          sign of the word being converted
//   seen_one      a 1 has already been seen in lower bits
//   res_bit       magnitude bit for this position
//   seen_one_next updated seen_one flag
module twos_neg_bit_cell (
  input  logic b,
  input  logic sign,
  input  logic seen_one,
  output logic res_bit,
  output logic seen_one_next
);

  always_comb begin
    res_bit       = (sign && seen_one) ? ~b : b;
    seen_one_next = seen_one | b;
  end

endmodule

// File: rtl/twos_to_signmag_serial.sv
// twos_to_signmag_serial: bit-serial two's-complement to sign-magnitude decoder.
// A word is accepted in IDLE, walked LSB-first for WIDTH cycles in SHIFT and
// presented in DONE until the consumer takes it.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake (in_ready high only in IDLE)
//   in_data             two's-complement input word
//   out_valid/out_ready output handshake
//   out_sign            sign bit of the input word
//   out_mag             unsigned magnitude
//   out_ovf             input was the most negative value 100..0
module twos_to_signmag_serial
  import twos_to_signmag_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] mag;
  logic [CW-1:0]    cnt;
  logic             sign;
  logic             seen_one;
  logic             ovf;
  logic             res_bit;
  logic             seen_one_next;

  twos_neg_bit_cell u_cell (
    .b             (word[cnt]),
    .sign          (sign),
    .seen_one      (seen_one),
    .res_bit       (res_bit),
    .seen_one_next (seen_one_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result bits enter from the MSB side so the first (LSB) bit processed
  // lands at bit 0 after WIDTH shifts. The overflow flag is settled on the
  // last shift so it becomes visible together with the magnitude.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word     <= '0;
      mag      <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
      seen_one <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word     <= in_data;
            sign     <= in_data[WIDTH-1];
            cnt      <= '0;
            seen_one <= 1'b0;
            mag      <= '0;
            ovf      <= 1'b0;
          end
        end
        SHIFT: begin
          mag      <= {res_bit, mag[WIDTH-1:1]};
          seen_one <= seen_one_next;
          cnt      <= cnt + CW'(1);
          if (cnt == LAST) ovf <= sign & (word[WIDTH-2:0] == '0);
        end
        default: ;
      endcase
    end
  end

  assign out_sign = sign;
  assign out_mag  = mag;
  assign out_ovf  = ovf;

endmodule
